// File: rtl/ex_div_if.sv
// Stall-interface bundle between the EX-stage divider and its requester/controller.
// master = pipeline side (drives the request), slave = divider.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               signed_i;
  logic [WIDTH-1:0]   op_a_i;
  logic [WIDTH-1:0]   op_b_i;
  logic               cancel_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_for_ex;

  modport master (
    output start_i, signed_i, op_a_i, op_b_i, cancel_i,
    input  result_o, ready_o, stallreq_for_ex
  );

  modport slave (
    input  start_i, signed_i, op_a_i, op_b_i, cancel_i,
    output result_o, ready_o, stallreq_for_ex
  );
endinterface

// File: rtl/ex_div_unit.sv
// Multi-cycle radix-2 restoring divider for the EX stage; returns {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in two cycles when |a| < |b|.
module ex_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      resetn,
  ex_div_if.slave   div_if
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [WIDTH-1:0]   r_divisor;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_early_rem;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_q_neg;
  logic               r_r_neg;
  logic               r_early;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic               w_b_zero;
  logic               w_early;
  logic               w_accept;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH+1:0]   w_trial;
  logic               w_borrow;
  logic [WIDTH-1:0]   w_quot_nxt;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [WIDTH-1:0]   w_quot_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic               w_unused;
  logic               w_ready;

  assign w_abs_a  = (div_if.signed_i && div_if.op_a_i[WIDTH-1]) ? -div_if.op_a_i : div_if.op_a_i;
  assign w_abs_b  = (div_if.signed_i && div_if.op_b_i[WIDTH-1]) ? -div_if.op_b_i : div_if.op_b_i;
  assign w_b_zero = (div_if.op_b_i == '0);
  assign w_accept = (r_state == S_IDLE) && div_if.start_i && !div_if.cancel_i;

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_b_zero && (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, keep the difference when no borrow.
  assign w_rem_sh   = {r_rem, r_quot[WIDTH-1]};
  assign w_trial    = {1'b0, w_rem_sh} - {2'b00, r_divisor};
  assign w_borrow   = w_trial[WIDTH+1];
  assign w_rem_nxt  = w_borrow ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quot_nxt = {r_quot[WIDTH-2:0], ~w_borrow};
  assign w_quot_fix = r_q_neg ? -w_quot_nxt : w_quot_nxt;
  assign w_rem_fix  = r_r_neg ? -w_rem_nxt  : w_rem_nxt;
  assign w_unused   = w_trial[WIDTH];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: default assignment first so no path through this block can infer a latch.
  always_comb begin
    w_next_state = r_state;
    if (div_if.cancel_i) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (div_if.start_i) begin
            // Early-out shares the one-cycle BY_ZERO slot so ready_o lands two cycles after start.
            if (w_b_zero || w_early) w_next_state = S_BY_ZERO;
            else                     w_next_state = S_ON;
          end
        end
        S_BY_ZERO: w_next_state = S_END;
        S_ON:      if (r_cnt == CNT_W'(WIDTH - 1)) w_next_state = S_END;
        S_END:     w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_ready = (r_state == S_END);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_divisor   <= '0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_early_rem <= '0;
      r_cnt       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_early     <= 1'b0;
      r_result    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_divisor   <= w_abs_b;
            r_quot      <= w_abs_a;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_q_neg     <= div_if.signed_i && (div_if.op_a_i[WIDTH-1] != div_if.op_b_i[WIDTH-1]);
            r_r_neg     <= div_if.signed_i && div_if.op_a_i[WIDTH-1];
            r_early     <= w_early;
            r_early_rem <= div_if.op_a_i;
          end
        end
        S_BY_ZERO: begin
          if (w_next_state == S_END)
            r_result <= r_early ? {r_early_rem, {WIDTH{1'b0}}} : '0;
        end
        S_ON: begin
          r_quot <= w_quot_nxt;
          r_rem  <= w_rem_nxt;
          r_cnt  <= r_cnt + 1'b1;
          if (w_next_state == S_END)
            r_result <= {w_rem_fix, w_quot_fix};
        end
        default: ;
      endcase
    end
  end

  assign div_if.ready_o         = w_ready;
  assign div_if.result_o        = r_result;
  assign div_if.stallreq_for_ex = div_if.start_i & ~w_ready;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed self-checking bench for ex_div_unit: latency, stall window, signed cases,
// divide-by-zero, cancel, back-to-back and reset behaviour.
module tb_ex_div_unit;

  localparam int WIDTH = 32;

  logic clk;
  logic resetn;
  int   checks = 0;
  int   errors = 0;

  ex_div_if #(.WIDTH(WIDTH)) div_if ();

  ex_div_unit #(.WIDTH(WIDTH), .CNT_W(6)) dut (
    .clk    (clk),
    .resetn (resetn),
    .div_if (div_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one division and hold start until END; cycle 0 is the cycle start rises.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg,
                        output logic [63:0] res, output int lat, output int stall_cnt,
                        output logic stall_at_ready);
    res = 'x; lat = -1; stall_cnt = 0; stall_at_ready = 1'bx;
    @(posedge clk); #1;
    div_if.op_a_i = a; div_if.op_b_i = b; div_if.signed_i = sg; div_if.start_i = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (div_if.stallreq_for_ex) stall_cnt++;
      if (div_if.ready_o) begin
        lat = k; res = div_if.result_o; stall_at_ready = div_if.stallreq_for_ex;
        break;
      end
    end
    @(posedge clk); #1;
    div_if.start_i = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    div_if.start_i = 1'b0; div_if.signed_i = 1'b0; div_if.cancel_i = 1'b0;
    div_if.op_a_i = '0; div_if.op_b_i = '0;
    #2;
    checks++; if (div_if.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", div_if.ready_o); end
    checks++; if (div_if.result_o !== 64'h0) begin errors++; $display("FAIL reset_result got %h exp 0", div_if.result_o); end
    div_if.start_i = 1'b1; #1;
    checks++; if (div_if.stallreq_for_ex !== 1'b1) begin errors++; $display("FAIL reset_stall_follows_start got %b exp 1", div_if.stallreq_for_ex); end
    div_if.start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_divu();
    logic [63:0] res; int lat, sc; logic sar;
    do_div(32'd100, 32'd7, 1'b0, res, lat, sc, sar);
    checks++; if (lat !== 33) begin errors++; $display("FAIL divu_latency got %0d exp 33", lat); end
    checks++; if (res !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_100_7 got %h exp %h", res, {32'd2, 32'd14}); end
    checks++; if (sc !== 33) begin errors++; $display("FAIL divu_stall_cycles got %0d exp 33", sc); end
    checks++; if (sar !== 1'b0) begin errors++; $display("FAIL divu_stall_at_end got %b exp 0", sar); end
    @(negedge clk);
    checks++; if (div_if.ready_o !== 1'b0) begin errors++; $display("FAIL divu_ready_one_cycle got %b exp 0", div_if.ready_o); end
    checks++; if (div_if.result_o !== {32'd2, 32'd14}) begin errors++; $display("FAIL divu_result_hold got %h exp %h", div_if.result_o, {32'd2, 32'd14}); end
  endtask

  task automatic test_by_zero();
    logic [63:0] res; int lat, sc; logic sar;
    do_div(32'd5, 32'd0, 1'b0, res, lat, sc, sar);
    checks++; if (lat !== 2) begin errors++; $display("FAIL byzero_latency got %0d exp 2", lat); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL byzero_result got %h exp 0", res); end
    checks++; if (sc !== 2) begin errors++; $display("FAIL byzero_stall_cycles got %0d exp 2", sc); end
  endtask

  task automatic test_signed();
    logic [63:0] res; int lat, sc; logic sar;
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, res, lat, sc, sar);
    checks++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_m7_2 got %h exp ffffffff_fffffffd", res); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_signed_latency got %0d exp 33", lat); end
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, res, lat, sc, sar);
    checks++; if (res !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL div_7_m2 got %h exp 00000001_fffffffd", res); end
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res, lat, sc, sar);
    checks++; if (res !== {32'h0, 32'h8000_0000}) begin errors++; $display("FAIL div_overflow got %h exp 00000000_80000000", res); end
    do_div(32'hFFFF_FFF9, 32'd2, 1'b0, res, lat, sc, sar);
    checks++; if (res !== {32'd1, 32'h7FFF_FFFC}) begin errors++; $display("FAIL divu_big got %h exp 00000001_7ffffffc", res); end
  endtask

  task automatic test_cancel();
    logic [63:0] res; int lat, sc; logic sar; int pulses;
    logic [63:0] prev;
    prev = div_if.result_o;
    @(posedge clk); #1;
    div_if.op_a_i = 32'd9; div_if.op_b_i = 32'd3; div_if.signed_i = 1'b0; div_if.start_i = 1'b1;
    repeat (10) @(posedge clk);
    #1 div_if.cancel_i = 1'b1; div_if.start_i = 1'b0;
    @(posedge clk); #1 div_if.cancel_i = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (div_if.ready_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL cancel_no_ready got %0d pulses exp 0", pulses); end
    checks++; if (div_if.result_o !== prev) begin errors++; $display("FAIL cancel_result_kept got %h exp %h", div_if.result_o, prev); end
    do_div(32'd9, 32'd3, 1'b0, res, lat, sc, sar);
    checks++; if (lat !== 33) begin errors++; $display("FAIL cancel_rerun_latency got %0d exp 33", lat); end
    checks++; if (res !== {32'd0, 32'd3}) begin errors++; $display("FAIL cancel_rerun_9_3 got %h exp %h", res, {32'd0, 32'd3}); end
  endtask

  task automatic test_back_to_back();
    int first, second; logic stall34; logic [63:0] r1, r2;
    first = -1; second = -1; stall34 = 1'bx; r1 = 'x; r2 = 'x;
    @(posedge clk); #1;
    div_if.op_a_i = 32'd20; div_if.op_b_i = 32'd3; div_if.signed_i = 1'b0; div_if.start_i = 1'b1;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (k == 34) stall34 = div_if.stallreq_for_ex;
      if (div_if.ready_o) begin
        if (first < 0) begin
          first = k; r1 = div_if.result_o;
          @(posedge clk); #1;
          div_if.op_a_i = 32'd21; div_if.op_b_i = 32'd4;
        end else begin
          second = k; r2 = div_if.result_o;
          break;
        end
      end
    end
    @(posedge clk); #1 div_if.start_i = 1'b0;
    checks++; if (first !== 33) begin errors++; $display("FAIL b2b_first_latency got %0d exp 33", first); end
    checks++; if (second !== 67) begin errors++; $display("FAIL b2b_second_latency got %0d exp 67", second); end
    checks++; if (r1 !== {32'd2, 32'd6}) begin errors++; $display("FAIL b2b_20_3 got %h exp %h", r1, {32'd2, 32'd6}); end
    checks++; if (r2 !== {32'd1, 32'd5}) begin errors++; $display("FAIL b2b_21_4 got %h exp %h", r2, {32'd1, 32'd5}); end
    checks++; if (stall34 !== 1'b1) begin errors++; $display("FAIL b2b_stall_reassert got %b exp 1", stall34); end
  endtask

  task automatic test_early_out();
    logic [63:0] res; int lat, sc; logic sar; int exp_lat;
`ifdef DIV_EARLY_OUT_EN
    exp_lat = 2;
`else
    exp_lat = 33;
`endif
    do_div(32'd3, 32'd10, 1'b0, res, lat, sc, sar);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL early_latency got %0d exp %0d", lat, exp_lat); end
    checks++; if (res !== {32'd3, 32'd0}) begin errors++; $display("FAIL early_3_10 got %h exp %h", res, {32'd3, 32'd0}); end
    checks++; if (sc !== exp_lat) begin errors++; $display("FAIL early_stall_cycles got %0d exp %0d", sc, exp_lat); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(posedge clk); #1;
    div_if.op_a_i = 32'd100; div_if.op_b_i = 32'd7; div_if.signed_i = 1'b0; div_if.start_i = 1'b1;
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    checks++; if (div_if.ready_o !== 1'b0) begin errors++; $display("FAIL rstmid_ready got %b exp 0", div_if.ready_o); end
    checks++; if (div_if.result_o !== 64'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0", div_if.result_o); end
    checks++; if (div_if.stallreq_for_ex !== 1'b1) begin errors++; $display("FAIL rstmid_stall got %b exp 1", div_if.stallreq_for_ex); end
    div_if.start_i = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (div_if.ready_o) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_ready got %0d exp 0", pulses); end
  endtask

  initial begin
    test_reset();
    test_divu();
    test_by_zero();
    test_signed();
    test_cancel();
    test_back_to_back();
    test_early_out();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
